// File: rtl/fsm_seq_detect.sv
// Runtime-programmable sliding-window sequence detector: compares the newest
// cfg_len_i accepted symbols against a register-file pattern, with a saturating hit counter.
module fsm_seq_detect #(
  parameter int WIDTH = 4,
  parameter int DEPTH = 8,
  parameter int CNT_W = 16,
  localparam int AW = $clog2(DEPTH),
  localparam int LW = $clog2(DEPTH + 1)
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             cfg_we_i,
  input  logic [AW-1:0]    cfg_addr_i,
  input  logic [WIDTH-1:0] cfg_data_i,
  input  logic [LW-1:0]    cfg_len_i,
  input  logic             cfg_overlap_i,
  input  logic             clear_i,
  input  logic             cnt_clr_i,
  input  logic             valid_i,
  input  logic [WIDTH-1:0] data_i,
  output logic             found_o,
  output logic [CNT_W-1:0] match_cnt_o
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [WIDTH-1:0] pat       [DEPTH];
  logic [WIDTH-1:0] hist      [DEPTH];
  logic [WIDTH-1:0] hist_next [DEPTH];
  logic [LW-1:0]    fill;
  logic [LW-1:0]    fill_next;
  logic [AW-1:0]    sel;
  logic             accept;
  logic             len_ok;
  logic             pat_eq;
  logic             hit;
  logic             addr_ok;

  // Out-of-range pattern addresses only exist when DEPTH is not a power of two.
  generate
    if ((1 << AW) == DEPTH) begin : g_addr_full
      assign addr_ok = 1'b1;
    end else begin : g_addr_part
      assign addr_ok = (int'(cfg_addr_i) < DEPTH);
    end
  endgenerate

  // Hit is judged on the history as it will look after this symbol is shifted in.
  always_comb begin
    accept    = valid_i && !clear_i && !cfg_we_i;
    fill_next = (fill == LW'(DEPTH)) ? fill : fill + LW'(1);
    len_ok    = (cfg_len_i != '0) && (cfg_len_i <= LW'(DEPTH));
    pat_eq    = 1'b1;
    sel       = '0;
    hist_next[0] = data_i;
    for (int i = 1; i < DEPTH; i++) begin
      hist_next[i] = hist[i-1];
    end
    for (int k = 0; k < DEPTH; k++) begin
      if (LW'(k) < cfg_len_i) begin
        sel = AW'(cfg_len_i - LW'(k + 1));
        if (pat[k] != hist_next[sel]) begin
          pat_eq = 1'b0;
        end
      end
    end
    hit = accept && len_ok && (fill_next >= cfg_len_i) && pat_eq;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int i = 0; i < DEPTH; i++) begin
        pat[i]  <= '0;
        hist[i] <= '0;
      end
      fill        <= '0;
      found_o     <= 1'b0;
      match_cnt_o <= '0;
    end else begin
      found_o <= hit;
      if (clear_i) begin
        fill <= '0;
      end else if (cfg_we_i) begin
        if (addr_ok) begin
          pat[cfg_addr_i] <= cfg_data_i;
        end
        fill <= '0;
      end else if (accept) begin
        for (int i = 0; i < DEPTH; i++) begin
          hist[i] <= hist_next[i];
        end
        // Non-overlapping mode restarts the window so the next hit needs fresh symbols.
        fill <= (hit && !cfg_overlap_i) ? '0 : fill_next;
      end

      if (cnt_clr_i) begin
        match_cnt_o <= '0;
      end else if (hit && (match_cnt_o != CNT_MAX)) begin
        match_cnt_o <= match_cnt_o + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_fsm_seq_detect.sv
// Scoreboard bench for fsm_seq_detect: each driven cycle queues its expected
// found/count, and a monitor compares them one cycle later.
module tb_fsm_seq_detect;

  localparam int WIDTH = 4;
  localparam int DEPTH = 8;
  localparam int CNT_W = 4;

  logic             clk_i = 1'b0;
  logic             rst_i = 1'b0;
  logic             cfg_we_i = 1'b0;
  logic [2:0]       cfg_addr_i = '0;
  logic [WIDTH-1:0] cfg_data_i = '0;
  logic [3:0]       cfg_len_i = '0;
  logic             cfg_overlap_i = 1'b0;
  logic             clear_i = 1'b0;
  logic             cnt_clr_i = 1'b0;
  logic             valid_i = 1'b0;
  logic [WIDTH-1:0] data_i = '0;
  logic             found_o;
  logic [CNT_W-1:0] match_cnt_o;

  typedef struct {
    logic             found;
    logic [CNT_W-1:0] cnt;
    string            tag;
  } exp_t;

  exp_t             sb_q[$];
  logic [CNT_W-1:0] cur_cnt = '0;
  int               checks = 0;
  int               failures = 0;

  fsm_seq_detect #(.WIDTH(WIDTH), .DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .cfg_we_i(cfg_we_i), .cfg_addr_i(cfg_addr_i),
    .cfg_data_i(cfg_data_i), .cfg_len_i(cfg_len_i), .cfg_overlap_i(cfg_overlap_i),
    .clear_i(clear_i), .cnt_clr_i(cnt_clr_i), .valid_i(valid_i), .data_i(data_i),
    .found_o(found_o), .match_cnt_o(match_cnt_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic checkOutput(input exp_t e);
    checks++;
    if (found_o !== e.found) begin
      failures++;
      $display("[TB] FAIL found %s: got %0b expected %0b", e.tag, found_o, e.found);
    end
    checks++;
    if (match_cnt_o !== e.cnt) begin
      failures++;
      $display("[TB] FAIL count %s: got %0d expected %0d", e.tag, match_cnt_o, e.cnt);
    end
  endtask

  // Monitor: outputs registered at a rising edge are compared 1 ns later.
  initial begin
    forever begin
      @(posedge clk_i);
      #1;
      if (sb_q.size() != 0) checkOutput(sb_q.pop_front());
    end
  end

  // Drives one cycle from the falling edge and queues the hand-given found bit.
  task automatic applyStimulus(input logic rst, input logic clr, input logic cclr,
                               input logic we, input logic [2:0] addr, input logic [3:0] wdata,
                               input logic vld, input logic [3:0] d, input logic ef,
                               input string tag);
    exp_t e;
    rst_i = rst; clear_i = clr; cnt_clr_i = cclr; cfg_we_i = we;
    cfg_addr_i = addr; cfg_data_i = wdata; valid_i = vld; data_i = d;
    if (rst || cclr) cur_cnt = '0;
    else if (ef && cur_cnt != 4'd15) cur_cnt = cur_cnt + 4'd1;
    e.found = ef;
    e.cnt   = cur_cnt;
    e.tag   = tag;
    sb_q.push_back(e);
    @(negedge clk_i);
  endtask

  task automatic sym(input logic [3:0] d, input logic ef, input string tag);
    applyStimulus(0, 0, 0, 0, 3'd0, 4'd0, 1, d, ef, tag);
  endtask

  task automatic bubble(input string tag);
    applyStimulus(0, 0, 0, 0, 3'd0, 4'd0, 0, 4'd0, 0, tag);
  endtask

  task automatic doClear(input string tag);
    applyStimulus(0, 1, 0, 0, 3'd0, 4'd0, 1, 4'd4, 0, tag);
  endtask

  task automatic doReset(input string tag);
    applyStimulus(1, 0, 0, 0, 3'd0, 4'd0, 1, 4'd4, 0, tag);
  endtask

  // Pattern writes present a symbol too, which must be dropped.
  task automatic wr(input logic [2:0] a, input logic [3:0] v, input string tag);
    applyStimulus(0, 0, 0, 1, a, v, 1, v, 0, tag);
  endtask

  initial begin
    doReset("reset0");
    doReset("reset1");

    cfg_len_i = 4'd4; cfg_overlap_i = 1'b0;
    wr(0, 1, "wr_basic"); wr(1, 0, "wr_basic"); wr(2, 2, "wr_basic"); wr(3, 4, "wr_basic");
    sym(1, 0, "basic_s1"); sym(0, 0, "basic_s2"); sym(2, 0, "basic_s3"); sym(4, 1, "basic_hit");

    sym(1, 0, "bub_s1"); sym(0, 0, "bub_s2"); sym(1, 0, "bub_s3");
    bubble("bub_idle1"); bubble("bub_idle2");
    sym(0, 0, "bub_s4"); sym(2, 0, "bub_s5"); sym(4, 1, "bub_hit");

    sym(1, 0, "restart_s1"); sym(1, 0, "restart_s2"); sym(0, 0, "restart_s3");
    sym(2, 0, "restart_s4"); sym(4, 1, "restart_hit");

    sym(1, 0, "clr_s1"); sym(0, 0, "clr_s2"); sym(2, 0, "clr_s3");
    doClear("clr_pulse"); sym(4, 0, "clr_nohit");

    sym(1, 0, "rst_s1"); sym(0, 0, "rst_s2"); sym(2, 0, "rst_s3");
    doReset("rst_pulse"); sym(4, 0, "rst_nohit");

    cfg_len_i = 4'd3; cfg_overlap_i = 1'b1;
    wr(0, 1, "wr_ov"); wr(1, 1, "wr_ov"); wr(2, 1, "wr_ov");
    sym(1, 0, "ov1_s1"); sym(1, 0, "ov1_s2"); sym(1, 1, "ov1_s3");
    sym(1, 1, "ov1_s4"); sym(1, 1, "ov1_s5");

    cfg_overlap_i = 1'b0; doClear("ov0_clr");
    sym(1, 0, "ov0_s1"); sym(1, 0, "ov0_s2"); sym(1, 1, "ov0_s3");
    sym(1, 0, "ov0_s4"); sym(1, 0, "ov0_s5");

    cfg_len_i = 4'd0; doClear("len0_clr");
    sym(1, 0, "len0_a"); sym(1, 0, "len0_b"); sym(1, 0, "len0_c");
    sym(0, 0, "len0_d"); sym(0, 0, "len0_e");

    cfg_len_i = 4'd1; wr(0, 7, "len1_wr_drop");
    sym(7, 1, "len1_hit1"); sym(3, 0, "len1_miss"); sym(7, 1, "len1_hit2");

    cfg_len_i = 4'd8; cfg_overlap_i = 1'b0;
    for (int i = 0; i < 8; i++) wr(3'(i), 4'(i + 1), "wr_len8");
    sym(9, 0, "len8_lead");
    for (int i = 1; i < 8; i++) sym(4'(i), 0, "len8_fill");
    sym(8, 1, "len8_hit");

    cfg_len_i = 4'd9; doClear("len9_clr");
    for (int i = 1; i < 9; i++) sym(4'(i), 0, "len9_nohit");

    cfg_len_i = 4'd1; cfg_overlap_i = 1'b1; wr(0, 7, "sat_wr");
    applyStimulus(0, 0, 1, 0, 3'd0, 4'd0, 0, 4'd0, 0, "sat_cclr");
    for (int i = 0; i < 17; i++) sym(7, 1, "sat_hit");
    bubble("sat_hold");
    applyStimulus(0, 0, 1, 0, 3'd0, 4'd0, 1, 4'd7, 1, "cclr_with_hit");
    sym(7, 1, "after_cclr");
    sym(3, 0, "after_cclr_miss");

    checks++;
    if (sb_q.size() != 0) begin
      failures++;
      $display("[TB] FAIL drain: got %0d pending expected 0", sb_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
